rom_stream_reader: RTL and testbench
====================================

// Module: rom_stream_reader
// PURPOSE
//  Upstream driver of the block ROM: takes a (base, length) read command, issues
//  sequential rom_addr/rom_en reads, absorbs the ROM's fixed 1-cycle read latency,
//  and emits the words as a valid/ready stream with backpressure. Sits between
//  control logic and compute consumers that read weights/data from the ROM.
// PARAMETERS
//  DATA_WIDTH  32        ROM word width; must match the ROM's RAM_WIDTH
//  ROM_DEPTH   32'h5_0000 words in the ROM; must match the ROM's RAM_DEPTH
//  ADDR_WIDTH  19        clogb2(ROM_DEPTH-1); must match the ROM's address width
//  FIFO_DEPTH  2         output buffer entries, power of 2, >=2; 2 gives full rate
// PORTS
//  clk        in   1           rising-edge clock, shared with ROM
//  rst        in   1           synchronous, active-high reset
//  start      in   1           command strobe; sampled only when busy==0
//  base_addr  in   ADDR_WIDTH  first word address
//  length     in   ADDR_WIDTH+1 word count, 0..ROM_DEPTH
//  busy       out  1           command accepted and not yet finished
//  done       out  1           1-cycle pulse at command end
//  err        out  1           1-cycle pulse, with done, on a rejected command
//  rom_addr   out  ADDR_WIDTH  to ROM addra
//  rom_en     out  1           to ROM en; one read per cycle at most
//  rom_dout   in   DATA_WIDTH  from ROM dout, valid 1 cycle after rom_en
//  m_valid    out  1           stream word available
//  m_ready    in   1           consumer accepts when m_valid&&m_ready
//  m_data     out  DATA_WIDTH  stream word
//  m_last     out  1           high with the final word of a command
// BEHAVIOUR
//  - Reset: busy=0, done=0, err=0, rom_en=0, rom_addr=0, m_valid=0, m_last=0;
//    FIFO emptied, in-flight flag cleared (ROM data returning after reset dropped).
//  - FSM IDLE -> RUN -> DRAIN -> IDLE.
//    IDLE: on start: if length==0 -> done pulse next cycle, stay IDLE, no reads.
//    If base_addr+length > ROM_DEPTH (ADDR_WIDTH+2-bit sum) -> done+err next
//    cycle, no reads. Else latch base/length, busy=1, go RUN.
//  - RUN: rom_en=1 when remaining>0 and fifo_count+inflight-pop < FIFO_DEPTH
//    (pop = m_valid&&m_ready this cycle). Each issue: rom_addr=current,
//    current+1, remaining-1. Last issue -> DRAIN.
//  - inflight: registered copy of rom_en; when set, rom_dout is written to FIFO
//    that cycle with a last-tag = (this was the final issued read).
//  - Credit rule guarantees the FIFO never overflows; no ROM read is ever lost.
//    Sustained 1 word/cycle when m_ready held high; first word m_valid 2 cycles
//    after start (1 cmd register + 1 ROM latency).
//  - m_data/m_valid/m_last are FIFO head; m_data stable while m_valid&&!m_ready.
//  - DRAIN: no issues; when last-tagged word handshakes -> done pulse next cycle,
//    busy=0, IDLE. start during busy is ignored (no queueing).
//  - Simultaneous FIFO push and pop at full/empty are both honoured.
//  - rst mid-command: immediate abort, no done/err, stream truncated without m_last.
//  - Address never wraps: range check at accept prevents addr >= ROM_DEPTH.
// STRUCTURE
//  - Shared include: clogb2 function (same as ROM) and ROM_DEPTH/DATA_WIDTH
//    defaults so ROM and reader cannot diverge.
//  - One sub-module: stream_fifo (sync, FIFO_DEPTH x (DATA_WIDTH+1) incl. last
//    tag, count output, push/pop same cycle allowed). FSM/counters in top.
// TESTING (bench instantiates the real ROM with a known hex init, word[i]=i)
//  1 base=0x10,len=4,m_ready=1 -> data 0x10..0x13 on 4 consecutive cycles,
//    m_last on 0x13, done 1 cycle later, rom_en high exactly 4 cycles.
//  2 base=0,len=8, m_ready toggles 1/0 each cycle -> 8 words in order, none lost
//    or duplicated, m_data stable during stalls, rom_en never with FIFO full.
//  3 len=0 -> done next cycle, err=0, no rom_en, no m_valid.
//  4 base=0x4FFFF,len=2 -> done+err next cycle, no rom_en; base=0x4FFFF,len=1 ->
//    one word 0x4FFFF with m_last.
//  5 rst asserted mid-stream of len=16 with m_ready=0 -> next cycle all outputs
//    at reset values; subsequent command base=0x20,len=2 yields only 0x20,0x21.
//  6 start pulsed while busy -> ignored; only the first command's words appear.

Source files
------------

// File: rtl/rom_stream_reader_pkg.sv
// Shared constants and helpers for the ROM stream reader and the ROM it drives.
// Latency: none (compile-time definitions only).
// Backpressure: n/a.
package rom_stream_reader_pkg;

  // Defaults kept here so the ROM and the reader cannot drift apart.
  localparam int          DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ROM_DEPTH  = 32'h5_0000;

  // Number of bits needed to represent 'value' (same helper the ROM uses).
  function automatic int clogb2(input int unsigned value);
    int unsigned v;
    int          r;
    v = value;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  localparam int DEF_ADDR_WIDTH = clogb2(DEF_ROM_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/rom_stream_reader_if.sv
// Command, ROM-port and output-stream bundle of the ROM stream reader.
// Latency: none (wires only).
// Backpressure: m_ready from the consumer; slave is the reader, master is its environment.
interface rom_stream_reader_if
  import rom_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
  // command side
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH:0]   length;
  logic                  busy;
  logic                  done;
  logic                  err;
  // ROM port
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic                  rom_en;
  logic [DATA_WIDTH-1:0] rom_dout;
  // output stream
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;

  modport slave (
    input  start, base_addr, length, rom_dout, m_ready,
    output busy, done, err, rom_addr, rom_en, m_valid, m_data, m_last
  );

  modport master (
    output start, base_addr, length, rom_dout, m_ready,
    input  busy, done, err, rom_addr, rom_en, m_valid, m_data, m_last
  );
endinterface

// File: rtl/rom_stream_reader_fifo.sv
// Small synchronous FIFO holding ROM words plus their last-tag.
// Latency: written entry visible at the head the cycle after push.
// Backpressure: push while full is dropped unless a pop happens the same cycle.
module rom_stream_reader_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW:0]      count_q;
  logic             full;
  logic             do_push;
  logic             do_pop;

  // Accept a push at full only when the head leaves in the same cycle.
  always_comb begin
    full    = (count_q == (PW+1)'(DEPTH));
    do_pop  = pop_i && (count_q != '0);
    do_push = push_i && (!full || do_pop);
  end

  // Storage array; contents need no reset because count_q gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers and occupancy; pointers wrap naturally for power-of-2 depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
endmodule

// File: rtl/rom_stream_reader.sv
// Turns a (base, length) command into sequential ROM reads and a valid/ready word stream.
// Latency: first m_valid two edges after the edge that samples start; then 1 word/cycle.
// Backpressure: reads are issued only against free FIFO credit, so m_ready stalls never lose data.
module rom_stream_reader
  import rom_stream_reader_pkg::*;
#(
  parameter int          DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ROM_DEPTH  = DEF_ROM_DEPTH,
  parameter int          ADDR_WIDTH = clogb2(ROM_DEPTH - 1),
  parameter int          FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  rom_stream_reader_if.slave bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] cur_q;
  logic [ADDR_WIDTH:0]   rem_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;
  logic                  inflight_q;
  logic                  inflight_last_q;

  logic [CW-1:0]         fifo_count;
  logic                  fifo_empty;
  logic [DATA_WIDTH:0]   fifo_rdata;

  logic                  pop;
  logic                  head_last;
  logic [CW:0]           occupancy;
  logic                  rom_en;
  logic                  issue_last;
  logic [ADDR_WIDTH+1:0] cmd_end;
  logic                  cmd_zero;
  logic                  cmd_oob;

  // Credit check and command screening; a read is issued only if its word
  // is guaranteed a FIFO slot when it returns one cycle later.
  always_comb begin
    head_last  = !fifo_empty && fifo_rdata[DATA_WIDTH];
    pop        = !fifo_empty && bus.m_ready;
    occupancy  = {1'b0, fifo_count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    rom_en     = (state_q == ST_RUN) && (rem_q != '0) &&
                 (occupancy < (CW+1)'(FIFO_DEPTH));
    issue_last = rom_en && (rem_q == (ADDR_WIDTH+1)'(1));
    cmd_end    = {2'b00, bus.base_addr} + {1'b0, bus.length};
    cmd_zero   = (bus.length == '0);
    cmd_oob    = (cmd_end > (ADDR_WIDTH+2)'(ROM_DEPTH));
  end

  // Command FSM: accept/reject in IDLE, issue reads in RUN, wait for the tagged word in DRAIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            if (cmd_zero) begin
              done_q <= 1'b1;
            end else if (cmd_oob) begin
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else begin
              cur_q   <= bus.base_addr;
              rem_q   <= bus.length;
              busy_q  <= 1'b1;
              state_q <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (rom_en) begin
            cur_q <= cur_q + ADDR_WIDTH'(1);
            rem_q <= rem_q - (ADDR_WIDTH+1)'(1);
            if (issue_last) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pop && head_last) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Tracks the read in the ROM pipeline; clearing it on reset drops stale returns.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      inflight_q      <= rom_en;
      inflight_last_q <= issue_last;
    end
  end

  rom_stream_reader_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (inflight_q),
    .wdata_i ({inflight_last_q, bus.rom_dout}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.rom_addr = cur_q;
  assign bus.rom_en   = rom_en;
  assign bus.m_valid  = !fifo_empty;
  assign bus.m_data   = fifo_rdata[DATA_WIDTH-1:0];
  assign bus.m_last   = head_last;
endmodule

// File: tb/tb_rom_stream_reader.sv
// Bench for rom_stream_reader with a behavioural ROM (word[i] = i).
// Expected streams come from the command rules: base..base+len-1, last on the final word.
module tb_rom_stream_reader;
  import rom_stream_reader_pkg::*;

  localparam int          DW    = DEF_DATA_WIDTH;
  localparam int unsigned DEPTH = DEF_ROM_DEPTH;
  localparam int          AW    = clogb2(DEPTH - 1);
  localparam int          FD    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rom_stream_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  rom_stream_reader #(
    .DATA_WIDTH (DW),
    .ROM_DEPTH  (DEPTH),
    .ADDR_WIDTH (AW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ROM with one cycle read latency, contents word[i] = i.
  always @(posedge clk) begin
    if (bus.rom_en) bus.rom_dout <= DW'(bus.rom_addr);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // observation records
  int rom_en_cnt, valid_cnt, busy_cnt, first_valid_cyc, done_cnt, done_cyc;
  int err_cnt, err_nodone, credit_viol, stall_viol, range_viol;
  int issued = 0, popped = 0;
  bit prev_stall = 0;
  logic [DW-1:0] prev_data;
  logic [DW:0] pop_q[$];
  int pop_cyc_q[$];
  int start_cyc;

  // reference model output
  logic [DW:0] exp_q[$];
  bit exp_err;

  always @(negedge clk) begin
    if (rst) begin
      issued = 0;
      popped = 0;
      prev_stall = 0;
    end else begin
      if (bus.rom_en) begin
        rom_en_cnt++;
        issued++;
        if (int'(bus.rom_addr) >= int'(DEPTH)) range_viol++;
      end
      if (bus.busy) busy_cnt++;
      if (bus.m_valid) begin
        valid_cnt++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (prev_stall && (!bus.m_valid || bus.m_data !== prev_data)) stall_viol++;
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
      if (bus.m_valid && bus.m_ready) begin
        pop_q.push_back({bus.m_last, bus.m_data});
        pop_cyc_q.push_back(cyc);
        popped++;
      end
      if (issued - popped > FD) credit_viol++;
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus.err) begin
        err_cnt++;
        if (!bus.done) err_nodone++;
      end
    end
  end

  task automatic clear_rec();
    rom_en_cnt = 0; valid_cnt = 0; busy_cnt = 0; first_valid_cyc = -1;
    done_cnt = 0; done_cyc = -1; err_cnt = 0; err_nodone = 0;
    credit_viol = 0; stall_viol = 0; range_viol = 0;
    pop_q.delete();
    pop_cyc_q.delete();
  endtask

  // Reference: the words a command must produce, or a rejection.
  task automatic build_exp(input logic [AW-1:0] b, input logic [AW:0] l);
    exp_q.delete();
    exp_err = 0;
    if (l == 0) return;
    if (int'(b) + int'(l) > int'(DEPTH)) begin
      exp_err = 1;
      return;
    end
    for (int i = 0; i < int'(l); i++) exp_q.push_back({(i == int'(l) - 1), DW'(int'(b) + i)});
  endtask

  task automatic drive_ready(input int mode);
    case (mode)
      0:       bus.m_ready = 1'b1;
      1:       bus.m_ready = (cyc % 2 == 0);
      2:       bus.m_ready = 1'b0;
      default: bus.m_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic run_cmd(input logic [AW-1:0] b, input logic [AW:0] l, input int mode,
                         input int budget, output bit to);
    @(posedge clk); #1;
    clear_rec();
    bus.start = 1'b1; bus.base_addr = b; bus.length = l;
    start_cyc = cyc;
    drive_ready(mode);
    @(posedge clk); #1;
    bus.start = 1'b0;
    drive_ready(mode);
    to = 1;
    for (int c = 0; c < budget; c++) begin
      if (done_cnt != 0) begin
        to = 0;
        break;
      end
      @(posedge clk); #1;
      drive_ready(mode);
    end
    repeat (4) begin
      @(posedge clk); #1;
      drive_ready(mode);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_checks++; if ({bus.done, bus.err} !== 2'b00) begin n_errors++; $display("FAIL reset_done_err: got %b want 00", {bus.done, bus.err}); end
    n_checks++; if (bus.rom_en !== 1'b0) begin n_errors++; $display("FAIL reset_rom_en: got %b want 0", bus.rom_en); end
    n_checks++; if (bus.rom_addr !== '0) begin n_errors++; $display("FAIL reset_rom_addr: got %0h want 0", bus.rom_addr); end
    n_checks++; if ({bus.m_valid, bus.m_last} !== 2'b00) begin n_errors++; $display("FAIL reset_stream: got %b want 00", {bus.m_valid, bus.m_last}); end
  endtask

  task automatic test_full_rate();
    bit to;
    run_cmd(AW'('h10), (AW+1)'(4), 0, 50, to);
    build_exp(AW'('h10), (AW+1)'(4));
    n_checks++; if (to !== 1'b0) begin n_errors++; $display("FAIL rate_timeout: no done within budget"); end
    n_checks++; if (pop_q.size() != exp_q.size()) begin n_errors++; $display("FAIL rate_count: got %0d want %0d", pop_q.size(), exp_q.size()); end
    for (int i = 0; i < pop_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (pop_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL rate_word[%0d]: got %0h want %0h", i, pop_q[i], exp_q[i]); end
      n_checks++; if (pop_cyc_q[i] != start_cyc + 3 + i) begin n_errors++; $display("FAIL rate_word_cycle[%0d]: got %0d want %0d", i, pop_cyc_q[i], start_cyc + 3 + i); end
    end
    n_checks++; if (first_valid_cyc != start_cyc + 3) begin n_errors++; $display("FAIL rate_first_valid: got %0d want %0d", first_valid_cyc, start_cyc + 3); end
    n_checks++; if (done_cyc != start_cyc + 7) begin n_errors++; $display("FAIL rate_done_cycle: got %0d want %0d", done_cyc, start_cyc + 7); end
    n_checks++; if (rom_en_cnt != 4) begin n_errors++; $display("FAIL rate_rom_en_cycles: got %0d want 4", rom_en_cnt); end
    n_checks++; if (done_cnt != 1 || err_cnt != 0) begin n_errors++; $display("FAIL rate_done_err: got done=%0d err=%0d want 1/0", done_cnt, err_cnt); end
    n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL rate_busy_after: got %b want 0", bus.busy); end
  endtask

  task automatic test_backpressure();
    bit to;
    run_cmd(AW'(0), (AW+1)'(8), 1, 100, to);
    build_exp(AW'(0), (AW+1)'(8));
    n_checks++; if (to !== 1'b0) begin n_errors++; $display("FAIL bp_timeout: no done within budget"); end
    n_checks++; if (pop_q.size() != exp_q.size()) begin n_errors++; $display("FAIL bp_count: got %0d want %0d", pop_q.size(), exp_q.size()); end
    for (int i = 0; i < pop_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (pop_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL bp_word[%0d]: got %0h want %0h", i, pop_q[i], exp_q[i]); end
    end
    n_checks++; if (stall_viol != 0) begin n_errors++; $display("FAIL bp_stall_stable: got %0d unstable stalls want 0", stall_viol); end
    n_checks++; if (credit_viol != 0) begin n_errors++; $display("FAIL bp_credit: got %0d overcommits want 0", credit_viol); end
    n_checks++; if (rom_en_cnt != 8) begin n_errors++; $display("FAIL bp_rom_reads: got %0d want 8", rom_en_cnt); end
  endtask

  task automatic test_zero_len();
    bit to;
    run_cmd(AW'('h55), (AW+1)'(0), 0, 20, to);
    n_checks++; if (done_cyc != start_cyc + 1) begin n_errors++; $display("FAIL zero_done_cycle: got %0d want %0d", done_cyc, start_cyc + 1); end
    n_checks++; if (err_cnt != 0) begin n_errors++; $display("FAIL zero_err: got %0d want 0", err_cnt); end
    n_checks++; if (rom_en_cnt != 0 || valid_cnt != 0 || busy_cnt != 0) begin n_errors++; $display("FAIL zero_activity: got rom_en=%0d valid=%0d busy=%0d want 0/0/0", rom_en_cnt, valid_cnt, busy_cnt); end
  endtask

  task automatic test_range();
    bit to;
    run_cmd(AW'('h4FFFF), (AW+1)'(2), 0, 20, to);
    n_checks++; if (done_cyc != start_cyc + 1 || done_cnt != 1) begin n_errors++; $display("FAIL oob_done: got cycle %0d count %0d want %0d/1", done_cyc, done_cnt, start_cyc + 1); end
    n_checks++; if (err_cnt != 1 || err_nodone != 0) begin n_errors++; $display("FAIL oob_err: got err=%0d err_without_done=%0d want 1/0", err_cnt, err_nodone); end
    n_checks++; if (rom_en_cnt != 0 || valid_cnt != 0) begin n_errors++; $display("FAIL oob_activity: got rom_en=%0d valid=%0d want 0/0", rom_en_cnt, valid_cnt); end
    run_cmd(AW'('h4FFFF), (AW+1)'(1), 0, 20, to);
    build_exp(AW'('h4FFFF), (AW+1)'(1));
    n_checks++; if (to !== 1'b0 || err_cnt != 0) begin n_errors++; $display("FAIL edge_done: got timeout=%0d err=%0d want 0/0", to, err_cnt); end
    n_checks++; if (pop_q.size() != 1) begin n_errors++; $display("FAIL edge_count: got %0d want 1", pop_q.size()); end
    n_checks++; if (pop_q.size() > 0 && pop_q[0] !== exp_q[0]) begin n_errors++; $display("FAIL edge_word: got %0h want %0h", pop_q[0], exp_q[0]); end
    n_checks++; if (range_viol != 0) begin n_errors++; $display("FAIL edge_addr_range: got %0d bad addresses want 0", range_viol); end
  endtask

  task automatic test_reset_mid();
    bit to;
    @(posedge clk); #1;
    clear_rec();
    bus.m_ready = 1'b0;
    bus.start = 1'b1; bus.base_addr = AW'('h40); bus.length = (AW+1)'(16);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    n_checks++; if ({bus.busy, bus.m_valid} !== 2'b11) begin n_errors++; $display("FAIL mid_precondition: got busy,valid=%b want 11", {bus.busy, bus.m_valid}); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if ({bus.busy, bus.done, bus.err} !== 3'b000) begin n_errors++; $display("FAIL mid_status: got busy,done,err=%b want 000", {bus.busy, bus.done, bus.err}); end
    n_checks++; if ({bus.rom_en, bus.m_valid, bus.m_last} !== 3'b000) begin n_errors++; $display("FAIL mid_outputs: got rom_en,valid,last=%b want 000", {bus.rom_en, bus.m_valid, bus.m_last}); end
    n_checks++; if (bus.rom_addr !== '0) begin n_errors++; $display("FAIL mid_rom_addr: got %0h want 0", bus.rom_addr); end
    run_cmd(AW'('h20), (AW+1)'(2), 0, 50, to);
    build_exp(AW'('h20), (AW+1)'(2));
    n_checks++; if (to !== 1'b0) begin n_errors++; $display("FAIL post_reset_timeout: no done within budget"); end
    n_checks++; if (pop_q.size() != exp_q.size()) begin n_errors++; $display("FAIL post_reset_count: got %0d want %0d", pop_q.size(), exp_q.size()); end
    for (int i = 0; i < pop_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (pop_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL post_reset_word[%0d]: got %0h want %0h", i, pop_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_start_busy();
    bit to;
    @(posedge clk); #1;
    clear_rec();
    bus.start = 1'b1; bus.base_addr = AW'('h30); bus.length = (AW+1)'(6);
    bus.m_ready = 1'($urandom_range(0, 1));
    to = 1;
    for (int c = 0; c < 200; c++) begin
      if (done_cnt != 0) begin
        to = 0;
        break;
      end
      @(posedge clk); #1;
      bus.start = (c == 1 || c == 3);
      bus.base_addr = AW'('h100);
      bus.length = (AW+1)'(3);
      bus.m_ready = 1'($urandom_range(0, 1));
    end
    bus.start = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      bus.m_ready = 1'b1;
    end
    build_exp(AW'('h30), (AW+1)'(6));
    n_checks++; if (to !== 1'b0) begin n_errors++; $display("FAIL busy_timeout: no done within budget"); end
    n_checks++; if (pop_q.size() != exp_q.size()) begin n_errors++; $display("FAIL busy_count: got %0d want %0d", pop_q.size(), exp_q.size()); end
    for (int i = 0; i < pop_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (pop_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL busy_word[%0d]: got %0h want %0h", i, pop_q[i], exp_q[i]); end
    end
    n_checks++; if (done_cnt != 1 || rom_en_cnt != 6) begin n_errors++; $display("FAIL busy_ignored: got done=%0d reads=%0d want 1/6", done_cnt, rom_en_cnt); end
  endtask

  task automatic test_random();
    bit to;
    logic [AW-1:0] b;
    logic [AW:0] l;
    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 3) == 0) b = AW'(DEPTH - $urandom_range(1, 10));
      else b = AW'($urandom_range(0, DEPTH - 1));
      l = (AW+1)'($urandom_range(0, 12));
      run_cmd(b, l, 3, 300, to);
      build_exp(b, l);
      n_checks++; if (to !== 1'b0 || done_cnt != 1) begin n_errors++; $display("FAIL rnd_done[%0d]: got timeout=%0d done=%0d want 0/1", t, to, done_cnt); end
      n_checks++; if (err_cnt != int'(exp_err)) begin n_errors++; $display("FAIL rnd_err[%0d]: base=%0h len=%0d got %0d want %0d", t, b, l, err_cnt, exp_err); end
      n_checks++; if (pop_q.size() != exp_q.size()) begin n_errors++; $display("FAIL rnd_count[%0d]: got %0d want %0d", t, pop_q.size(), exp_q.size()); end
      for (int i = 0; i < pop_q.size() && i < exp_q.size(); i++) begin
        n_checks++; if (pop_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL rnd_word[%0d][%0d]: got %0h want %0h", t, i, pop_q[i], exp_q[i]); end
      end
      n_checks++; if (credit_viol != 0 || stall_viol != 0 || range_viol != 0) begin n_errors++; $display("FAIL rnd_protocol[%0d]: got credit=%0d stall=%0d range=%0d want 0/0/0", t, credit_viol, stall_viol, range_viol); end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.length = '0;
    bus.m_ready = 1'b0;
    clear_rec();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_full_rate();
    test_backpressure();
    test_zero_len();
    test_range();
    test_reset_mid();
    test_start_busy();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
